ring_buf_arbiter: RTL and testbench

Two-producer, one-consumer front end for the `RingBuf` 32-bit word FIFO. It arbitrates between two valid/ready write requesters using round-robin with bounded bursts. It also applies backpressure so the buffer's overwrite-oldest overflow path never fires, and it presents the buffer head as a valid/ready stream. It sits between the I/O receive paths (UART RX packer, debug injector) and the core's MMIO input port.

---
 rtl/ring_buf_arbiter_pkg.sv | 15 +
 rtl/ring_buf_arbiter_ring_buf.sv | 64 ++++++
 rtl/ring_buf_arbiter.sv | 143 ++++++++++++++
 tb/tb_ring_buf_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ring_buf_arbiter_pkg.sv
// Shared types and constants for the two-producer RingBuf front end.
package ring_buf_arbiter_pkg;

    typedef logic [31:0] w32;
    typedef logic [31:0] r32;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        R0   = 2'd1,
        R1   = 2'd2
    } owner_t;

    localparam int unsigned RING_BUF_DEPTH = 512;

endpackage

// File: rtl/ring_buf_arbiter_ring_buf.sv
// RingBuf: 32-bit word ring FIFO holding BUF_SIZE-1 words; a write when full
// overwrites the oldest word and pulses overflow.
module RingBuf
    import ring_buf_arbiter_pkg::*;
#(
    parameter int unsigned BUF_SIZE = RING_BUF_DEPTH
) (
    input  logic clock,
    input  logic reset,
    input  logic we,
    input  w32   wd,
    input  logic re,
    output w32   rd,
    output r32   size,
    output logic overflow
);

    localparam int unsigned AW = (BUF_SIZE > 2) ? $clog2(BUF_SIZE) : 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(BUF_SIZE - 1);
    localparam r32 FULL = r32'(BUF_SIZE - 1);

    w32            mem [BUF_SIZE];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    r32            count;
    logic          do_re;

    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == LAST_IDX) ? '0 : p + AW'(1);
    endfunction

    assign do_re    = re & (count != '0);
    assign overflow = we & ~do_re & (count == FULL);
    assign rd       = mem[rd_ptr];
    assign size     = count;

    always_ff @(posedge clock) begin
        if (we) begin
            mem[wr_ptr] <= wd;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (we) begin
                wr_ptr <= bump(wr_ptr);
            end
            // Overwrite-oldest drags the read pointer along with the write.
            if (do_re | overflow) begin
                rd_ptr <= bump(rd_ptr);
            end
            if (we & ~do_re & ~overflow) begin
                count <= count + r32'(1);
            end else if (do_re & ~we) begin
                count <= count - r32'(1);
            end
        end
    end

endmodule

// File: rtl/ring_buf_arbiter.sv
// Round-robin, burst-bounded arbiter of two writers into RingBuf with full-buffer backpressure.
// Define RING_BUF_ARBITER_STATS_EN to build the accept / full-stall statistics counters.
module ring_buf_arbiter
    import ring_buf_arbiter_pkg::*;
#(
    parameter int unsigned BUF_SIZE  = RING_BUF_DEPTH,
    parameter int unsigned BURST_LEN = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic req0_valid,
    input  w32   req0_data,
    output logic req0_ready,
    input  logic req1_valid,
    input  w32   req1_data,
    output logic req1_ready,
    output logic out_valid,
    output w32   out_data,
    input  logic out_ready,
    output r32   level,
    output logic err_overflow,
    output r32   stat_accept0,
    output r32   stat_accept1,
    output r32   stat_full_stall
);

    localparam r32 FULL_LEVEL = r32'(BUF_SIZE - 1);
    localparam logic [7:0] BURST_MAX = 8'(BURST_LEN);

    owner_t     owner_q, owner_d;
    owner_t     last_q, last_d;
    owner_t     pick;
    logic [7:0] beats_q, beats_d;
    logic       err_q;

    logic pop;
    logic space;
    logic owner_valid;
    logic burst_open;
    logic accept;
    logic overflow;
    w32   wd;

    assign pop        = out_valid & out_ready;
    assign space      = (level < FULL_LEVEL) | pop;
    assign out_valid  = (level != '0);
    assign burst_open = (beats_q < BURST_MAX);
    assign owner_valid = ((owner_q == R0) & req0_valid) | ((owner_q == R1) & req1_valid);

    always_comb begin
        pick = NONE;
        if (owner_valid && burst_open) begin
            pick = owner_q;
        end else if (req0_valid && !req1_valid) begin
            pick = R0;
        end else if (req1_valid && !req0_valid) begin
            pick = R1;
        end else if (req0_valid && req1_valid) begin
            pick = (last_q == R0) ? R1 : R0;
        end
    end

    assign req0_ready = space & (pick == R0) & ~reset;
    assign req1_ready = space & (pick == R1) & ~reset;
    assign accept     = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    assign wd         = req0_ready ? req0_data : req1_data;

    // A stall on a full buffer leaves the burst intact; only an idle owner ends it.
    always_comb begin
        owner_d = owner_q;
        beats_d = beats_q;
        last_d  = last_q;
        if (accept) begin
            if ((pick == owner_q) && burst_open) begin
                beats_d = beats_q + 8'd1;
            end else begin
                owner_d = pick;
                beats_d = 8'd1;
            end
            last_d = pick;
        end else if (space && !owner_valid) begin
            owner_d = NONE;
            beats_d = 8'd0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            owner_q <= NONE;
            beats_q <= 8'd0;
            last_q  <= R1;
            err_q   <= 1'b0;
        end else begin
            owner_q <= owner_d;
            beats_q <= beats_d;
            last_q  <= last_d;
            err_q   <= err_q | overflow;
        end
    end

    assign err_overflow = err_q;

    RingBuf #(
        .BUF_SIZE (BUF_SIZE)
    ) u_ring_buf (
        .clock    (clock),
        .reset    (reset),
        .we       (accept),
        .wd       (wd),
        .re       (pop),
        .rd       (out_data),
        .size     (level),
        .overflow (overflow)
    );

`ifdef RING_BUF_ARBITER_STATS_EN
    r32   accept0_q, accept1_q, full_stall_q;
    logic full_stall;

    assign full_stall = (req0_valid | req1_valid) & ~space;

    always_ff @(posedge clock) begin
        if (reset) begin
            accept0_q    <= '0;
            accept1_q    <= '0;
            full_stall_q <= '0;
        end else begin
            if (req0_valid & req0_ready) accept0_q <= accept0_q + r32'(1);
            if (req1_valid & req1_ready) accept1_q <= accept1_q + r32'(1);
            if (full_stall) full_stall_q <= full_stall_q + r32'(1);
        end
    end

    assign stat_accept0    = accept0_q;
    assign stat_accept1    = accept1_q;
    assign stat_full_stall = full_stall_q;
`else
    assign stat_accept0    = '0;
    assign stat_accept1    = '0;
    assign stat_full_stall = '0;
`endif

endmodule

// File: tb/tb_ring_buf_arbiter.sv
// Self-checking bench for ring_buf_arbiter (BUF_SIZE=8, BURST_LEN=4): vector table plus
// hand-written corner sequences, with a FIFO scoreboard checking every popped word.
module tb_ring_buf_arbiter;

    localparam int unsigned BUF_SIZE  = 8;
    localparam int unsigned BURST_LEN = 4;

    logic        clock;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        out_valid, out_ready;
    logic [31:0] out_data;
    logic [31:0] level;
    logic        err_overflow;
    logic [31:0] stat_accept0, stat_accept1, stat_full_stall;

    ring_buf_arbiter #(
        .BUF_SIZE  (BUF_SIZE),
        .BURST_LEN (BURST_LEN)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .req0_valid      (req0_valid),
        .req0_data       (req0_data),
        .req0_ready      (req0_ready),
        .req1_valid      (req1_valid),
        .req1_data       (req1_data),
        .req1_ready      (req1_ready),
        .out_valid       (out_valid),
        .out_data        (out_data),
        .out_ready       (out_ready),
        .level           (level),
        .err_overflow    (err_overflow),
        .stat_accept0    (stat_accept0),
        .stat_accept1    (stat_accept1),
        .stat_full_stall (stat_full_stall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic v0;
        logic v1;
        logic ordy;
        logic rdy0;
        logic rdy1;
    } vec_t;

    vec_t        vecs [13];
    logic [31:0] sb [$];
    int          n_cmp;
    int          n_fail;
    logic        acc0, acc1;
    int          d0, d1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Samples handshakes at the falling edge, then returns 1 time unit after the rising edge.
    task automatic tick();
        @(negedge clock);
        acc0 = req0_valid & req0_ready;
        acc1 = req1_valid & req1_ready;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL pop_unexpected: got 0x%0h, want no pop", out_data);
            end else begin
                check("pop_data", out_data, sb.pop_front());
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        out_ready = 1'b0;
        reset     = 1'b1;
        tick();
        reset     = 1'b0;
        sb.delete();
    endtask

    task automatic drain();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        out_ready  = 1'b1;
        for (int i = 0; i < int'(BUF_SIZE) + 4 && level != 0; i++) tick();
        out_ready = 1'b0;
        check("drain_level", level, 32'd0);
        check("drain_scoreboard", sb.size(), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        for (int i = 0; i < 12; i++) begin
            vecs[i].v0   = 1'b1;
            vecs[i].v1   = 1'b1;
            vecs[i].ordy = 1'b1;
            vecs[i].rdy0 = (i < 4) || (i >= 8);
            vecs[i].rdy1 = (i >= 4) && (i < 8);
        end
        vecs[12] = '{v0: 1'b0, v1: 1'b0, ordy: 1'b1, rdy0: 1'b0, rdy1: 1'b0};

        reset      = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_data  = '0;
        req1_data  = '0;
        out_ready  = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        // Reset state, with both requesters asserting valid during reset.
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        tick();
        check("reset_ready0", 32'(acc0), 32'd0);
        check("reset_ready1", 32'(acc1), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_level", level, 32'd0);
        check("reset_err_overflow", 32'(err_overflow), 32'd0);
        check("reset_stat_accept0", stat_accept0, 32'd0);
        check("reset_stat_accept1", stat_accept1, 32'd0);
        check("reset_stat_full_stall", stat_full_stall, 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        reset      = 1'b0;

        // R0 alone streams 0x10..0x14 into a stalled consumer, then everything is popped.
        req0_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req0_data = 32'h10 + 32'(i);
            sb.push_back(req0_data);
            tick();
            check($sformatf("stream_accept%0d", i), 32'(acc0), 32'd1);
        end
        req0_valid = 1'b0;
        check("stream_level", level, 32'd5);
        check("stream_out_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        out_ready = 1'b0;
        check("stream_empty", 32'(out_valid), 32'd0);

        // Both requesters continuously valid: bursts of four alternate starting with R0.
        do_reset();
        d0 = 0;
        d1 = 0;
        for (int i = 0; i < 13; i++) begin
            req0_valid = vecs[i].v0;
            req1_valid = vecs[i].v1;
            out_ready  = vecs[i].ordy;
            req0_data  = 32'hA0 + 32'(d0);
            req1_data  = 32'hB0 + 32'(d1);
            if (vecs[i].rdy0) sb.push_back(req0_data);
            if (vecs[i].rdy1) sb.push_back(req1_data);
            tick();
            check($sformatf("arb%0d_ready0", i), 32'(acc0), 32'(vecs[i].rdy0));
            check($sformatf("arb%0d_ready1", i), 32'(acc1), 32'(vecs[i].rdy1));
            if (acc0) d0++;
            if (acc1) d1++;
        end
        check("arb_err_overflow", 32'(err_overflow), 32'd0);
        drain();

        // Fill to capacity, then accept and pop in the same cycle at the full level.
        out_ready  = 1'b0;
        req0_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req0_data = 32'h30 + 32'(i);
            if (i < 7) sb.push_back(req0_data);
            tick();
            check($sformatf("full_accept%0d", i), 32'(acc0), 32'(i < 7));
        end
        check("full_level", level, 32'd7);
        out_ready = 1'b1;
        sb.push_back(req0_data);
        tick();
        check("full_pop_accept", 32'(acc0), 32'd1);
        out_ready  = 1'b0;
        req0_valid = 1'b0;
        check("full_level_hold", level, 32'd7);
        check("full_err_overflow", 32'(err_overflow), 32'd0);
        drain();

        // A full-buffer stall at beats=2 must not end R0's burst.
        do_reset();
        req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req1_data = 32'hC0 + 32'(i);
            sb.push_back(req1_data);
            tick();
            check($sformatf("stall_prefill%0d", i), 32'(acc1), 32'd1);
        end
        req1_valid = 1'b0;
        req0_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req0_data = 32'hD0 + 32'(i);
            sb.push_back(req0_data);
            tick();
            check($sformatf("stall_r0_beat%0d", i + 1), 32'(acc0), 32'd1);
        end
        check("stall_level", level, 32'd7);
        req0_data  = 32'hD2;
        req1_valid = 1'b1;
        req1_data  = 32'hC5;
        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("stall_hold%0d_ready0", i), 32'(acc0), 32'd0);
            check($sformatf("stall_hold%0d_ready1", i), 32'(acc1), 32'd0);
        end
        out_ready = 1'b1;
        sb.push_back(req0_data);
        tick();
        check("stall_beat3_r0", 32'(acc0), 32'd1);
        check("stall_beat3_r1", 32'(acc1), 32'd0);
        req0_data = 32'hD3;
        sb.push_back(req0_data);
        tick();
        check("stall_beat4_r0", 32'(acc0), 32'd1);
        check("stall_beat4_r1", 32'(acc1), 32'd0);
        sb.push_back(req1_data);
        tick();
        check("stall_handover_r0", 32'(acc0), 32'd0);
        check("stall_handover_r1", 32'(acc1), 32'd1);
        check("stall_level_after", level, 32'd7);
        drain();

        // Reset in the middle of a mixed burst at level 3.
        do_reset();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_data  = 32'hE0;
        req1_data  = 32'hF0;
        for (int i = 0; i < 3; i++) tick();
        check("midrst_level_before", level, 32'd3);
        reset = 1'b1;
        tick();
        check("midrst_ready0", 32'(acc0), 32'd0);
        check("midrst_ready1", 32'(acc1), 32'd0);
        reset = 1'b0;
        sb.delete();
        check("midrst_level", level, 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        sb.push_back(req0_data);
        tick();
        check("midrst_first_r0", 32'(acc0), 32'd1);
        check("midrst_first_r1", 32'(acc1), 32'd0);
        drain();

        // Statistics: 6 R0 accepts, 2 R1 accepts, 3 full-stall cycles.
        do_reset();
        req0_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req0_data = 32'h50 + 32'(i);
            sb.push_back(req0_data);
            tick();
            check($sformatf("stats_r0_%0d", i), 32'(acc0), 32'd1);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        req1_data  = 32'h60;
        sb.push_back(req1_data);
        tick();
        check("stats_r1_first", 32'(acc1), 32'd1);
        req1_data = 32'h61;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stats_stall%0d", i), 32'(acc1), 32'd0);
        end
        out_ready = 1'b1;
        sb.push_back(req1_data);
        tick();
        check("stats_r1_second", 32'(acc1), 32'd1);
        req1_valid = 1'b0;
        out_ready  = 1'b0;
`ifdef RING_BUF_ARBITER_STATS_EN
        check("stat_accept0", stat_accept0, 32'd6);
        check("stat_accept1", stat_accept1, 32'd2);
        check("stat_full_stall", stat_full_stall, 32'd3);
`else
        check("stat_accept0_tied", stat_accept0, 32'd0);
        check("stat_accept1_tied", stat_accept1, 32'd0);
        check("stat_full_stall_tied", stat_full_stall, 32'd0);
`endif
        check("stats_err_overflow", 32'(err_overflow), 32'd0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
